// File: rtl/spi_responder.sv
// spi_responder: 1/2/4-lane SPI target. Oversamples the SPI pins in the clk domain,
// deserializes MOSI words onto a valid/ready RX port and serializes TX words onto MISO.
module spi_responder #(
    parameter int                DATA_W      = 8,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] TX_IDLE     = DATA_W'(8'hFF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic [3:0]        spi_mosi,
    output logic [3:0]        spi_miso,
    output logic              spi_miso_oe,
    input  logic [1:0]        cfg_lanes,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              busy,
    output logic              err_frame,
    output logic              err_overrun,
    input  logic              err_clr
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [0:0] {IDLE, SHIFT} state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0]      sclk_sync, cs_sync, warm;
    logic [SYNC_STAGES-1:0][3:0] mosi_sync;
    logic                        sclk_p0, cs_p0, sclk_p1, cs_p1, armed;
    logic [3:0]                  mosi_p0;
    logic                        sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic                        start, stop, rise_act, fall_act, fetch, word_done;
    logic [2:0]                  lanes_q, lane_sel;
    logic [CNT_W-1:0]            bit_cnt, cnt_sum;
    logic [DATA_W-1:0]           tx_shift, tx_adv, fetch_word, rx_shift, rx_next;

    function automatic logic [2:0] lane_count(input logic [1:0] cfg);
        case (cfg)
            2'd1:    lane_count = 3'd2;
            2'd2:    lane_count = 3'd4;
            default: lane_count = 3'd1;
        endcase
    endfunction

    // Lanes at or above the active count are forced to 0.
    function automatic logic [3:0] beat_of(input logic [DATA_W-1:0] word, input logic [2:0] lanes);
        case (lanes)
            3'd2:    beat_of = {2'b00, word[1:0]};
            3'd4:    beat_of = word[3:0];
            default: beat_of = {3'b000, word[0]};
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] rx, input logic [3:0] mosi,
                                                   input logic [2:0] lanes);
        case (lanes)
            3'd2:    shift_in = {mosi[1:0], rx[DATA_W-1:2]};
            3'd4:    shift_in = {mosi[3:0], rx[DATA_W-1:4]};
            default: shift_in = {mosi[0], rx[DATA_W-1:1]};
        endcase
    endfunction

    // Stage p0: synchronized pins; stage p1: one-cycle delayed copy for edge detection.
    assign sclk_p0 = sclk_sync[SYNC_STAGES-1];
    assign cs_p0   = cs_sync[SYNC_STAGES-1];
    assign mosi_p0 = mosi_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            warm      <= '0;
            sclk_p1   <= 1'b0;
            cs_p1     <= 1'b1;
            armed     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            warm      <= {warm[SYNC_STAGES-2:0], 1'b1};
            sclk_p1   <= sclk_p0;
            cs_p1     <= cs_p0;
            // Arm only once a real (non-reset) high level of cs_n has reached the sync output.
            if (warm[SYNC_STAGES-1] && cs_p0)
                armed <= 1'b1;
        end
    end

    assign sclk_rise = sclk_p0 & ~sclk_p1;
    assign sclk_fall = ~sclk_p0 & sclk_p1;
    assign cs_fall   = armed & cs_p1 & ~cs_p0;
    assign cs_rise   = cs_p0 & ~cs_p1;

    always_comb begin
        state_next = state;
        start      = 1'b0;
        stop       = 1'b0;
        rise_act   = 1'b0;
        fall_act   = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_next = SHIFT;
                    start      = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_next = IDLE;
                    stop       = 1'b1;
                end else begin
                    rise_act = sclk_rise;
                    fall_act = sclk_fall;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign lane_sel   = start ? lane_count(cfg_lanes) : lanes_q;
    assign fetch      = start | (fall_act & (bit_cnt == '0));
    assign fetch_word = tx_valid ? tx_data : TX_IDLE;
    assign tx_ready   = fetch & tx_valid & ~rst;
    assign tx_adv     = tx_shift >> lanes_q;
    assign rx_next    = shift_in(rx_shift, mosi_p0, lanes_q);
    assign cnt_sum    = bit_cnt + CNT_W'(lanes_q);
    assign word_done  = rise_act & (cnt_sum == CNT_W'(DATA_W));
    assign busy       = (state == SHIFT);

    // Stage p2: control state, MISO drive, RX handshake and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            lanes_q     <= 3'd1;
            bit_cnt     <= '0;
            spi_miso    <= 4'h0;
            spi_miso_oe <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            err_frame   <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            state <= state_next;
            if (start) begin
                lanes_q     <= lane_sel;
                bit_cnt     <= '0;
                spi_miso_oe <= 1'b1;
            end
            if (stop) begin
                bit_cnt     <= '0;
                spi_miso    <= 4'h0;
                spi_miso_oe <= 1'b0;
            end else if (fetch) begin
                spi_miso <= beat_of(fetch_word, lane_sel);
            end else if (fall_act) begin
                spi_miso <= beat_of(tx_adv, lanes_q);
            end
            if (rise_act)
                bit_cnt <= word_done ? '0 : cnt_sum;
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;
            if (word_done && !(rx_valid && !rx_ready)) begin
                rx_data  <= rx_next;
                rx_valid <= 1'b1;
            end
            err_frame   <= (err_frame & ~err_clr) | (stop & (bit_cnt != '0));
            err_overrun <= (err_overrun & ~err_clr) | (word_done & rx_valid & ~rx_ready);
        end
    end

    always_ff @(posedge clk) begin
        if (fetch)
            tx_shift <= fetch_word;
        else if (fall_act)
            tx_shift <= tx_adv;
        if (rise_act)
            rx_shift <= rx_next;
    end

endmodule

// File: tb/tb_spi_responder.sv
// tb_spi_responder: directed SPI master bench for spi_responder with hand-computed expectations.
module tb_spi_responder;

    localparam int DATA_W = 8;
    localparam int HALF   = 80;

    logic              clk = 1'b0;
    logic              rst;
    logic              spi_sclk;
    logic              spi_cs_n;
    logic [3:0]        spi_mosi;
    logic [3:0]        spi_miso;
    logic              spi_miso_oe;
    logic [1:0]        cfg_lanes;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              busy;
    logic              err_frame;
    logic              err_overrun;
    logic              err_clr;

    int         n_checks  = 0;
    int         n_errors  = 0;
    int         tx_pulses = 0;
    logic [7:0] rx_q[$];
    logic [3:0] miso_hi;
    logic [7:0] m;

    always #5 clk = ~clk;

    spi_responder #(.DATA_W(DATA_W), .SYNC_STAGES(2), .TX_IDLE(8'hFF)) dut (
        .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .cfg_lanes(cfg_lanes),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .err_frame(err_frame), .err_overrun(err_overrun), .err_clr(err_clr)
    );

    // Stimulus changes 2 ns after posedge, so the falling edge is a quiet sampling point.
    always @(negedge clk) begin
        if (tx_ready) tx_pulses++;
        if (rx_valid && rx_ready) rx_q.push_back(rx_data);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic spi_word(input logic [7:0] w, input int l, output logic [7:0] mo);
        logic [3:0] b;
        logic [2:0] idx;
        mo = 8'h00;
        for (int i = 0; i < 8 / l; i++) begin
            b = 4'h0;
            for (int k = 0; k < l; k++) begin
                idx = 3'(l * i + k);
                b[2'(k)] = w[idx];
            end
            spi_mosi = b;
            #HALF;
            for (int k = 0; k < 4; k++) begin
                if (k < l) begin
                    idx = 3'(l * i + k);
                    mo[idx] = spi_miso[2'(k)];
                end else begin
                    miso_hi[2'(k)] = miso_hi[2'(k)] | spi_miso[2'(k)];
                end
            end
            spi_sclk = 1'b1;
            #HALF;
            spi_sclk = 1'b0;
        end
    endtask

    task automatic one_beat(input logic [3:0] b);
        spi_mosi = b;
        #HALF;
        spi_sclk = 1'b1;
        #HALF;
        spi_sclk = 1'b0;
    endtask

    task automatic cs_start();
        spi_cs_n = 1'b0;
        #HALF;
    endtask

    task automatic cs_end();
        #HALF;
        spi_cs_n = 1'b1;
        #(4 * HALF);
    endtask

    task automatic drain();
        rx_ready = 1'b1;
        #20;
        rx_ready = 1'b0;
        #10;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        #10;
        err_clr = 1'b0;
        #10;
    endtask

    initial begin
        rst = 1'b1; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 4'h0; cfg_lanes = 2'd0;
        rx_ready = 1'b0; tx_data = 8'h00; tx_valid = 1'b0; err_clr = 1'b0; miso_hi = 4'h0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        #20;
        check("rst_miso", 32'(spi_miso), 32'h0);
        check("rst_oe", 32'(spi_miso_oe), 32'h0);
        check("rst_rx_valid", 32'(rx_valid), 32'h0);
        check("rst_rx_data", 32'(rx_data), 32'h0);
        check("rst_tx_ready", 32'(tx_ready), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_flags", 32'({err_frame, err_overrun}), 32'h0);

        // 4-lane receive of 0xA5 with no TX word queued
        cfg_lanes = 2'd2;
        cs_start();
        spi_word(8'hA5, 4, m);
        cs_end();
        check("q4_rx_data", 32'(rx_data), 32'hA5);
        check("q4_rx_valid", 32'(rx_valid), 32'h1);
        check("q4_miso_idle", 32'(m), 32'hFF);
        check("q4_flags", 32'({err_frame, err_overrun}), 32'h0);
        check("q4_busy_after", 32'(busy), 32'h0);
        check("q4_oe_after", 32'(spi_miso_oe), 32'h0);
        #100;
        check("q4_rx_hold", 32'(rx_valid), 32'h1);
        drain();
        check("q4_rx_cleared", 32'(rx_valid), 32'h0);

        // 4-lane transmit of 0x3C
        tx_pulses = 0;
        tx_data = 8'h3C;
        tx_valid = 1'b1;
        cs_start();
        tx_valid = 1'b0;
        check("tx_busy", 32'(busy), 32'h1);
        check("tx_oe", 32'(spi_miso_oe), 32'h1);
        spi_word(8'h00, 4, m);
        cs_end();
        check("tx_ready_pulses", 32'(tx_pulses), 32'd1);
        check("tx_miso_word", 32'(m), 32'h3C);
        drain();

        // 1-lane, three words, consumer always ready
        rx_q.delete();
        miso_hi = 4'h0;
        cfg_lanes = 2'd0;
        rx_ready = 1'b1;
        cs_start();
        spi_word(8'h01, 1, m);
        check("l1_miso0", 32'(m), 32'hFF);
        spi_word(8'h80, 1, m);
        check("l1_miso1", 32'(m), 32'hFF);
        spi_word(8'hFF, 1, m);
        check("l1_miso2", 32'(m), 32'hFF);
        cs_end();
        rx_ready = 1'b0;
        check("l1_rx_count", 32'(rx_q.size()), 32'd3);
        check("l1_rx0", (rx_q.size() > 0) ? 32'(rx_q[0]) : 32'hDEAD, 32'h01);
        check("l1_rx1", (rx_q.size() > 1) ? 32'(rx_q[1]) : 32'hDEAD, 32'h80);
        check("l1_rx2", (rx_q.size() > 2) ? 32'(rx_q[2]) : 32'hDEAD, 32'hFF);
        check("l1_unused_lanes", 32'(miso_hi), 32'h0);
        check("l1_flags", 32'({err_frame, err_overrun}), 32'h0);

        // 2-lane overrun: second word dropped while first is unconsumed
        cfg_lanes = 2'd1;
        cs_start();
        spi_word(8'h12, 2, m);
        spi_word(8'h34, 2, m);
        cs_end();
        check("ov_rx_data", 32'(rx_data), 32'h12);
        check("ov_rx_valid", 32'(rx_valid), 32'h1);
        check("ov_overrun", 32'(err_overrun), 32'h1);
        check("ov_frame", 32'(err_frame), 32'h0);
        pulse_clr();
        check("ov_cleared", 32'(err_overrun), 32'h0);
        drain();

        // Frame error: cs_n rises after one 4-lane beat
        cfg_lanes = 2'd2;
        cs_start();
        one_beat(4'h7);
        #HALF;
        check("fe_busy_mid", 32'(busy), 32'h1);
        spi_cs_n = 1'b1;
        #(4 * HALF);
        check("fe_err_frame", 32'(err_frame), 32'h1);
        check("fe_rx_valid", 32'(rx_valid), 32'h0);
        check("fe_busy", 32'(busy), 32'h0);
        check("fe_oe", 32'(spi_miso_oe), 32'h0);
        check("fe_miso", 32'(spi_miso), 32'h0);
        pulse_clr();
        check("fe_cleared", 32'(err_frame), 32'h0);

        // Reset mid-frame, released with cs_n still low
        cs_start();
        one_beat(4'h1);
        rst = 1'b1;
        #20;
        rst = 1'b0;
        tx_pulses = 0;
        tx_data = 8'h99;
        tx_valid = 1'b1;
        spi_word(8'h77, 4, m);
        #HALF;
        check("rr_rx_valid", 32'(rx_valid), 32'h0);
        check("rr_rx_data", 32'(rx_data), 32'h0);
        check("rr_busy", 32'(busy), 32'h0);
        check("rr_oe", 32'(spi_miso_oe), 32'h0);
        check("rr_miso", 32'(spi_miso), 32'h0);
        check("rr_tx_pulses", 32'(tx_pulses), 32'd0);
        tx_valid = 1'b0;
        spi_cs_n = 1'b1;
        #(4 * HALF);
        cs_start();
        spi_word(8'h5A, 4, m);
        cs_end();
        check("rr_rx_5a", 32'(rx_data), 32'h5A);
        check("rr_rx_valid2", 32'(rx_valid), 32'h1);
        check("rr_flags", 32'({err_frame, err_overrun}), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
